irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller between NUM_IRQ peripheral sources and the
// core's single interrupt input.
//
// Each source is synchronised, latched (edge mode) or followed (level mode)
// into PEND. It is then masked by MASK and arbitrated by fixed priority, with
// channel 0 the highest. One request at a time is presented on irq_o. The
// acknowledged channel stays in service until the core signals end-of-interrupt.
//
// Handshake: irq_o is high only in REQ. The core answers with a single-cycle
// ack_i pulse, which latches the current winner into vector_o and moves to
// SERVICE. A single-cycle eoi_i pulse in SERVICE returns to IDLE. An ack_i
// outside REQ, or an eoi_i outside SERVICE, is ignored.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous reset, active-high
//   src_i     raw interrupt sources [NUM_IRQ]
//   we_i      register write strobe
//   addr_i    register select: 0 MASK, 1 MODE, 2 PEND (W1C), 3 STATUS
//   wdata_i   write data (bits above NUM_IRQ ignored)
//   rdata_o   read data, combinational from addr_i
//   irq_o     registered request to core
//   ack_i     core acknowledge pulse
//   eoi_i     end-of-interrupt pulse
//   vector_o  registered vector of the acknowledged channel
// STATUS = {state[1:0], in_svc_valid, 2'b0, in_svc_id[2:0]}; this also
// exposes the FSM state for observation.
module irq_ctrl #(
  parameter int          NUM_IRQ     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  VEC_BASE    = 8'h20
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] src_i,
  input  logic               we_i,
  input  logic [1:0]         addr_i,
  input  logic [7:0]         wdata_i,
  output logic [7:0]         rdata_o,
  output logic               irq_o,
  input  logic               ack_i,
  input  logic               eoi_i,
  output logic [7:0]         vector_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] s_prev;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] mode;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [1:0]         state;
  logic [2:0]         win;
  logic [2:0]         in_svc_id;
  logic               in_svc_valid;
  logic               ack_take;

  assign s        = sync_q[SYNC_STAGES-1];
  assign req      = pend & mask;
  assign ack_take = (state == ST_REQ) && ack_i && (req != '0);

  // Synchroniser chain plus one extra flop for rising-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev <= '0;
    end else begin
      sync_q[0] <= src_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev <= s;
    end
  end

  // Fixed priority: scan from the top down, so the lowest set index wins.
  always_comb begin
    win = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (req[k]) win = 3'(k);
    end
  end

  // Next PEND. In edge mode a new edge beats a same-cycle clear (W1C or ack).
  // In level mode PEND simply follows the synchronised source.
  always_comb begin
    w1c     = (we_i && addr_i == 2'd2) ? wdata_i[NUM_IRQ-1:0] : '0;
    ack_clr = '0;
    pend_d  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (ack_take && win == 3'(k)) ack_clr[k] = 1'b1;
    end
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (mode[k]) pend_d[k] = (s[k] & ~s_prev[k]) | (pend[k] & ~w1c[k] & ~ack_clr[k]);
      else         pend_d[k] = s[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask <= '0;
      mode <= '0;
      pend <= '0;
    end else begin
      pend <= pend_d;
      if (we_i && addr_i == 2'd0) mask <= wdata_i[NUM_IRQ-1:0];
      if (we_i && addr_i == 2'd1) mode <= wdata_i[NUM_IRQ-1:0];
    end
  end

  // Request/service FSM. SERVICE never raises a new request (no nesting).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      irq_o        <= 1'b0;
      vector_o     <= '0;
      in_svc_id    <= '0;
      in_svc_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != '0) begin
            state <= ST_REQ;
            irq_o <= 1'b1;
          end
        end
        ST_REQ: begin
          if (req == '0) begin
            state <= ST_IDLE;
            irq_o <= 1'b0;
          end else if (ack_i) begin
            state        <= ST_SERVICE;
            irq_o        <= 1'b0;
            vector_o     <= VEC_BASE + {5'b0, win};
            in_svc_id    <= win;
            in_svc_valid <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (eoi_i) begin
            state        <= ST_IDLE;
            in_svc_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      2'd0:    rdata_o[NUM_IRQ-1:0] = mask;
      2'd1:    rdata_o[NUM_IRQ-1:0] = mode;
      2'd2:    rdata_o[NUM_IRQ-1:0] = pend;
      default: rdata_o = {state, in_svc_valid, 2'b00, in_svc_id};
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (default parameters: 8 channels, 2 sync stages,
// vector base 8'h20). Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so each tick() observes the state that one edge
// produced.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] src;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;
  logic       ack;
  logic       eoi;
  logic [7:0] vector;

  int checks   = 0;
  int failures = 0;

  // Expected vectors, pushed by the stimulus and popped at each acknowledge.
  logic [7:0] exp_q[$];

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_MODE = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  irq_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .src_i    (src),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .irq_o    (irq),
    .ack_i    (ack),
    .eoi_i    (eoi),
    .vector_o (vector)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0; addr = A_STAT;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    read_reg(a, d);
    check(tag, d, exp);
  endtask

  task automatic do_ack(input string tag);
    logic [7:0] e;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, vector, e);
    check({tag, "_irq_low"}, {7'b0, irq}, 8'h00);
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0; we = 1'b0; addr = A_STAT; wdata = '0; ack = 1'b0; eoi = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();

    // 1: reset state, then single edge pulse on channel 0.
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_vector", vector, 8'h00);
    check_reg("rst_status", A_STAT, 8'h00);
    check_reg("rst_mask", A_MASK, 8'h00);
    write_reg(A_MASK, 8'h01);
    write_reg(A_MODE, 8'h01);
    check_reg("t1_mask_rd", A_MASK, 8'h01);
    src = 8'h01;
    tick();                         // E0 samples the pulse
    src = 8'h00;
    tick();                         // E1
    check_reg("t1_pend_e1", A_PEND, 8'h00);
    tick();                         // E2
    check_reg("t1_pend_e2", A_PEND, 8'h01);
    check("t1_irq_e2", {7'b0, irq}, 8'h00);
    tick();                         // E3
    check("t1_irq_e3", {7'b0, irq}, 8'h01);
    check_reg("t1_status_req", A_STAT, 8'h40);
    exp_q.push_back(8'h20);
    do_ack("t1_vec");
    check_reg("t1_pend_acked", A_PEND, 8'h00);
    check_reg("t1_status_svc", A_STAT, 8'hA0);
    do_eoi();
    check_reg("t1_status_idle", A_STAT, 8'h00);
    tick();
    check("t1_irq_after_eoi", {7'b0, irq}, 8'h00);

    // 2: two simultaneous edges, priority picks channel 2 then 5.
    write_reg(A_MASK, 8'hFF);
    write_reg(A_MODE, 8'hFF);
    src = 8'h24;
    tick(3);
    check_reg("t2_pend", A_PEND, 8'h24);
    tick();
    check("t2_irq", {7'b0, irq}, 8'h01);
    exp_q.push_back(8'h22);
    do_ack("t2_vec_a");
    check_reg("t2_status_a", A_STAT, 8'hA2);
    check_reg("t2_pend_a", A_PEND, 8'h20);
    do_eoi();
    check("t2_irq_eoi_edge", {7'b0, irq}, 8'h00);
    tick();
    check("t2_irq_rearm", {7'b0, irq}, 8'h01);
    exp_q.push_back(8'h25);
    do_ack("t2_vec_b");
    check_reg("t2_status_b", A_STAT, 8'hA5);
    check_reg("t2_pend_b", A_PEND, 8'h00);
    do_eoi();
    src = 8'h00;
    tick(3);

    // 3: level mode channel 3 re-requests after EOI while held high.
    write_reg(A_MODE, 8'h00);
    write_reg(A_MASK, 8'h08);
    src = 8'h08;
    tick(3);
    check_reg("t3_pend", A_PEND, 8'h08);
    tick();
    check("t3_irq", {7'b0, irq}, 8'h01);
    exp_q.push_back(8'h23);
    do_ack("t3_vec");
    check_reg("t3_pend_level_kept", A_PEND, 8'h08);
    check_reg("t3_status_svc", A_STAT, 8'hA3);
    do_eoi();
    tick();
    check("t3_irq_rearm", {7'b0, irq}, 8'h01);
    src = 8'h00;
    tick(3);
    check_reg("t3_pend_dropped", A_PEND, 8'h00);
    tick();
    check("t3_irq_dropped", {7'b0, irq}, 8'h00);
    check_reg("t3_status_idle", A_STAT, 8'h03);

    // 4: masking a pending request withdraws irq without clearing PEND.
    write_reg(A_MODE, 8'hFF);
    write_reg(A_MASK, 8'h02);
    src = 8'h02;
    tick(4);
    check("t4_irq", {7'b0, irq}, 8'h01);
    src = 8'h00;
    write_reg(A_MASK, 8'h00);
    tick();
    check("t4_irq_masked", {7'b0, irq}, 8'h00);
    check_reg("t4_pend_kept", A_PEND, 8'h02);
    check_reg("t4_status_idle", A_STAT, 8'h03);
    write_reg(A_MASK, 8'h02);
    tick();
    check("t4_irq_unmasked", {7'b0, irq}, 8'h01);
    exp_q.push_back(8'h21);
    do_ack("t4_vec");
    do_eoi();

    // 5: W1C colliding with a new edge loses; plain W1C clears; stray ack ignored.
    src = 8'h10;
    tick(2);                        // E0, E1: edge lands at the next edge
    write_reg(A_PEND, 8'h10);       // W1C at the same edge as the set
    check_reg("t5_set_wins", A_PEND, 8'h10);
    write_reg(A_PEND, 8'h10);
    check_reg("t5_w1c", A_PEND, 8'h00);
    check_reg("t5_status_pre", A_STAT, 8'h01);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_reg("t5_status_ack_idle", A_STAT, 8'h01);
    check("t5_vector_held", vector, 8'h21);
    check("t5_irq", {7'b0, irq}, 8'h00);
    src = 8'h00;
    tick(3);

    // 6: reset during SERVICE.
    write_reg(A_MASK, 8'hFF);
    src = 8'h10;
    tick(4);
    check("t6_irq", {7'b0, irq}, 8'h01);
    exp_q.push_back(8'h24);
    do_ack("t6_vec");
    check_reg("t6_status_svc", A_STAT, 8'hA4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    src = 8'h00;
    check("t6_irq_rst", {7'b0, irq}, 8'h00);
    check("t6_vector_rst", vector, 8'h00);
    check_reg("t6_status_rst", A_STAT, 8'h00);
    check_reg("t6_mask_rst", A_MASK, 8'h00);
    check_reg("t6_mode_rst", A_MODE, 8'h00);
    check_reg("t6_pend_rst", A_PEND, 8'h00);
    tick(3);
    check("t6_irq_quiet", {7'b0, irq}, 8'h00);

    // Final report.
    check("exp_q_drained", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
